// File: rtl/rob_head_if.sv
// rob_head_if -- view of the reorder-buffer head as seen by the retire unit.
//
// Carries COMMIT_W head slots (slot 0 is the oldest) from the ROB to the
// retire unit, and the number of entries the retire unit pops each cycle
// back to the ROB.
//
// Handshake: a slot is offered while rob_valid[i] is high. The retire unit
// answers in the same cycle with rob_retire_cnt; the ROB must pop exactly
// that many entries from the head on the next rising clock edge. A count
// of 0 means nothing is taken and the ROB keeps presenting the same head.
//
// Modports:
//   master : ROB side (drives the slots, reads rob_retire_cnt)
//   slave  : retire unit side (reads the slots, drives rob_retire_cnt)
interface rob_head_if #(
  parameter int COMMIT_W  = 4,
  parameter int XLEN      = 32,
  parameter int PHYS_W    = 6,
  parameter int ROB_IDX_W = 5
);
  localparam int CNT_W = $clog2(COMMIT_W + 1);

  logic [COMMIT_W-1:0]                 rob_valid;
  logic [COMMIT_W-1:0][ROB_IDX_W-1:0]  rob_idx;
  logic [COMMIT_W-1:0][4:0]            rob_arch_rd;
  logic [COMMIT_W-1:0][PHYS_W-1:0]     rob_phys_rd;
  logic [COMMIT_W-1:0]                 rob_exc;
  logic [COMMIT_W-1:0][4:0]            rob_exc_cause;
  logic [COMMIT_W-1:0]                 rob_is_store;
  logic [COMMIT_W-1:0]                 rob_is_branch;
  logic [COMMIT_W-1:0]                 rob_br_taken;
  logic [COMMIT_W-1:0]                 rob_br_mispred;
  logic [COMMIT_W-1:0][XLEN-1:0]       rob_br_target;
  logic [COMMIT_W-1:0][XLEN-1:0]       rob_pc;
  logic [CNT_W-1:0]                    rob_retire_cnt;

  modport master (
    output rob_valid, rob_idx, rob_arch_rd, rob_phys_rd, rob_exc, rob_exc_cause,
           rob_is_store, rob_is_branch, rob_br_taken, rob_br_mispred,
           rob_br_target, rob_pc,
    input  rob_retire_cnt
  );

  modport slave (
    input  rob_valid, rob_idx, rob_arch_rd, rob_phys_rd, rob_exc, rob_exc_cause,
           rob_is_store, rob_is_branch, rob_br_taken, rob_br_mispred,
           rob_br_target, rob_pc,
    output rob_retire_cnt
  );
endinterface

// File: rtl/retire_unit.sv
// retire_unit -- in-order commit stage, up to COMMIT_W entries per cycle.
//
// Picks the longest retirable prefix of the ROB head (combinational
// rob_retire_cnt), and one cycle later pulses the side effects: free-list
// releases, committed-RAT updates, store commit, branch-predictor update,
// flush / exception. An exception or a mispredict puts the unit in RECOVER
// for exactly one cycle, during which nothing retires.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   rob                   rob_head_if.slave (head slots in, retire count out)
//   lsu_st_ready_i        LSU can accept a store commit this cycle
//   lsu_st_commit_en_o/lsu_st_rob_idx_o            store commit pulse
//   freelist_free_en_o/freelist_free_phys_o        per-slot phys release
//   rat_commit_en_o/rat_commit_arch_o/rat_commit_phys_o  per-slot commit
//   bp_upd_*_o            branch-predictor training pulse
//   flush_o/flush_pc_o    pipeline flush pulse and redirect target
//   exc_valid_o/exc_cause_o/exc_pc_o               exception report
//   mtvec_wen_i/mtvec_wdata_i                      trap-vector write
//   perf_*_o              64-bit performance counters
//   state_dbg_o           1 while in RECOVER
//
// Store handshake: a store slot retires only while lsu_st_ready_i is high;
// the commit pulse lsu_st_commit_en_o follows on the next cycle.
//
// Build option: define RETIRE_PERF_COUNTERS_EN to implement the perf_*
// counters; otherwise those outputs are tied to 0.
module retire_unit #(
  parameter int COMMIT_W  = 4,
  parameter int XLEN      = 32,
  parameter int PHYS_W    = 6,
  parameter int ROB_IDX_W = 5,
  parameter int ARCH_REGS = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  rob_head_if.slave                          rob,
  input  logic                               lsu_st_ready_i,
  output logic                               lsu_st_commit_en_o,
  output logic [ROB_IDX_W-1:0]               lsu_st_rob_idx_o,
  output logic [COMMIT_W-1:0]                freelist_free_en_o,
  output logic [COMMIT_W-1:0][PHYS_W-1:0]    freelist_free_phys_o,
  output logic [COMMIT_W-1:0]                rat_commit_en_o,
  output logic [COMMIT_W-1:0][4:0]           rat_commit_arch_o,
  output logic [COMMIT_W-1:0][PHYS_W-1:0]    rat_commit_phys_o,
  output logic                               bp_upd_en_o,
  output logic [XLEN-1:0]                    bp_upd_pc_o,
  output logic                               bp_upd_taken_o,
  output logic [XLEN-1:0]                    bp_upd_target_o,
  output logic                               flush_o,
  output logic [XLEN-1:0]                    flush_pc_o,
  output logic                               exc_valid_o,
  output logic [4:0]                         exc_cause_o,
  output logic [XLEN-1:0]                    exc_pc_o,
  input  logic                               mtvec_wen_i,
  input  logic [XLEN-1:0]                    mtvec_wdata_i,
  output logic [63:0]                        perf_retired_o,
  output logic [63:0]                        perf_cycles_o,
  output logic [63:0]                        perf_exc_o,
  output logic [63:0]                        perf_mispred_o,
  output logic                               state_dbg_o
);
  localparam int CNT_W = $clog2(COMMIT_W + 1);

  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_e;

  state_e                          state_q;
  logic [XLEN-1:0]                 mtvec_q;
  logic [PHYS_W-1:0]               rat_q [ARCH_REGS];
  logic [PHYS_W-1:0]               rat_d [ARCH_REGS];

  logic [CNT_W-1:0]                cnt_d;
  logic [COMMIT_W-1:0]             retire_mask;
  logic                            exc_take, mis_take;
  logic                            stop, seen_store, seen_branch;
  logic                            st_en_d;
  logic [ROB_IDX_W-1:0]            st_idx_d;
  logic                            bp_en_d, bp_taken_d;
  logic [XLEN-1:0]                 bp_pc_d, bp_target_d, flush_pc_d;
  logic [COMMIT_W-1:0]             free_en_d;
  logic [COMMIT_W-1:0][PHYS_W-1:0] free_phys_d, commit_phys_d;
  logic [COMMIT_W-1:0][4:0]        commit_arch_d;

  // Retirable prefix. At most one store and one branch per group; an
  // exception on slot 0 pops that entry alone, anywhere else it just ends
  // the prefix; a mispredicted branch retires and then ends the prefix.
  always_comb begin
    cnt_d       = '0;
    retire_mask = '0;
    exc_take    = 1'b0;
    mis_take    = 1'b0;
    stop        = reset || (state_q != RUN);
    seen_store  = 1'b0;
    seen_branch = 1'b0;
    st_en_d     = 1'b0;
    st_idx_d    = '0;
    bp_en_d     = 1'b0;
    bp_taken_d  = 1'b0;
    bp_pc_d     = '0;
    bp_target_d = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (!stop) begin
        if (!rob.rob_valid[i]) begin
          stop = 1'b1;
        end else if (rob.rob_exc[i]) begin
          if (i == 0) begin
            exc_take = 1'b1;
            cnt_d    = CNT_W'(1);
          end
          stop = 1'b1;
        end else if (rob.rob_is_store[i] && (seen_store || !lsu_st_ready_i)) begin
          stop = 1'b1;
        end else if (rob.rob_is_branch[i] && seen_branch) begin
          stop = 1'b1;
        end else begin
          retire_mask[i] = 1'b1;
          cnt_d          = cnt_d + CNT_W'(1);
          if (rob.rob_is_store[i]) begin
            seen_store = 1'b1;
            st_en_d    = 1'b1;
            st_idx_d   = rob.rob_idx[i];
          end
          if (rob.rob_is_branch[i]) begin
            seen_branch = 1'b1;
            bp_en_d     = 1'b1;
            bp_pc_d     = rob.rob_pc[i];
            bp_taken_d  = rob.rob_br_taken[i];
            bp_target_d = rob.rob_br_target[i];
            if (rob.rob_br_mispred[i]) begin
              mis_take = 1'b1;
              stop     = 1'b1;
            end
          end
        end
      end
    end
  end

  // Committed-RAT walk in slot order: each slot frees whatever the mapping
  // was after the older slots of the same group were applied, so duplicate
  // destinations chain correctly and the youngest writer wins.
  always_comb begin
    rat_d         = rat_q;
    free_en_d     = '0;
    free_phys_d   = '0;
    commit_arch_d = '0;
    commit_phys_d = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (retire_mask[i]) begin
        commit_arch_d[i] = rob.rob_arch_rd[i];
        commit_phys_d[i] = rob.rob_phys_rd[i];
        if (rob.rob_arch_rd[i] != 5'd0) begin
          free_en_d[i]                = 1'b1;
          free_phys_d[i]              = rat_d[rob.rob_arch_rd[i]];
          rat_d[rob.rob_arch_rd[i]]   = rob.rob_phys_rd[i];
        end
      end
    end
  end

  always_comb begin
    flush_pc_d = '0;
    if (exc_take)      flush_pc_d = mtvec_q;
    else if (mis_take) flush_pc_d = bp_taken_d ? bp_target_d : bp_pc_d + XLEN'(4);
  end

  assign rob.rob_retire_cnt = cnt_d;
  assign state_dbg_o        = (state_q == RECOVER);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q              <= RUN;
      mtvec_q              <= XLEN'(32'h0000_0100);
      for (int r = 0; r < ARCH_REGS; r++) rat_q[r] <= PHYS_W'(r);
      lsu_st_commit_en_o   <= 1'b0;
      lsu_st_rob_idx_o     <= '0;
      freelist_free_en_o   <= '0;
      freelist_free_phys_o <= '0;
      rat_commit_en_o      <= '0;
      rat_commit_arch_o    <= '0;
      rat_commit_phys_o    <= '0;
      bp_upd_en_o          <= 1'b0;
      bp_upd_pc_o          <= '0;
      bp_upd_taken_o       <= 1'b0;
      bp_upd_target_o      <= '0;
      flush_o              <= 1'b0;
      flush_pc_o           <= '0;
      exc_valid_o          <= 1'b0;
      exc_cause_o          <= '0;
      exc_pc_o             <= '0;
    end else begin
      case (state_q)
        RUN:     state_q <= (exc_take || mis_take) ? RECOVER : RUN;
        RECOVER: state_q <= RUN;
        default: state_q <= RUN;
      endcase
      // The exception in this same cycle has already sampled the old value.
      if (mtvec_wen_i) mtvec_q <= mtvec_wdata_i;
      rat_q                <= rat_d;
      lsu_st_commit_en_o   <= st_en_d;
      lsu_st_rob_idx_o     <= st_idx_d;
      freelist_free_en_o   <= free_en_d;
      freelist_free_phys_o <= free_phys_d;
      rat_commit_en_o      <= retire_mask;
      rat_commit_arch_o    <= commit_arch_d;
      rat_commit_phys_o    <= commit_phys_d;
      bp_upd_en_o          <= bp_en_d;
      bp_upd_pc_o          <= bp_pc_d;
      bp_upd_taken_o       <= bp_taken_d;
      bp_upd_target_o      <= bp_target_d;
      flush_o              <= exc_take || mis_take;
      flush_pc_o           <= flush_pc_d;
      exc_valid_o          <= exc_take;
      exc_cause_o          <= exc_take ? rob.rob_exc_cause[0] : 5'd0;
      exc_pc_o             <= exc_take ? rob.rob_pc[0] : '0;
    end
  end

`ifdef RETIRE_PERF_COUNTERS_EN
  logic [63:0] perf_retired_q, perf_cycles_q, perf_exc_q, perf_mispred_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_retired_q <= '0;
      perf_cycles_q  <= '0;
      perf_exc_q     <= '0;
      perf_mispred_q <= '0;
    end else begin
      perf_cycles_q  <= perf_cycles_q + 64'd1;
      // The exception pop is not counted as a retirement.
      perf_retired_q <= perf_retired_q + 64'($countones(retire_mask));
      perf_exc_q     <= perf_exc_q + 64'(exc_take);
      perf_mispred_q <= perf_mispred_q + 64'(mis_take);
    end
  end

  assign perf_retired_o = perf_retired_q;
  assign perf_cycles_o  = perf_cycles_q;
  assign perf_exc_o     = perf_exc_q;
  assign perf_mispred_o = perf_mispred_q;
`else
  assign perf_retired_o = '0;
  assign perf_cycles_o  = '0;
  assign perf_exc_o     = '0;
  assign perf_mispred_o = '0;
`endif
endmodule

// File: tb/tb_retire_unit.sv
// tb_retire_unit -- directed bench for retire_unit (COMMIT_W=4, XLEN=32).
// A negedge process compares every output against a slot-level model of
// the commit rules each cycle; the stimulus sequence additionally pins
// hand-computed values for the key scenarios.
module tb_retire_unit;
  localparam int CW = 4;

  typedef struct packed {
    logic        valid;
    logic [4:0]  idx;
    logic [4:0]  arch;
    logic [5:0]  phys;
    logic        exc;
    logic [4:0]  cause;
    logic        st;
    logic        br;
    logic        taken;
    logic        mis;
    logic [31:0] target;
    logic [31:0] pc;
  } slot_t;

  typedef struct packed {
    logic            st_en;
    logic [4:0]      st_idx;
    logic [3:0]      free_en;
    logic [3:0][5:0] free_phys;
    logic [3:0]      rat_en;
    logic [3:0][4:0] rat_arch;
    logic [3:0][5:0] rat_phys;
    logic            bp_en;
    logic [31:0]     bp_pc;
    logic            bp_taken;
    logic [31:0]     bp_target;
    logic            flush;
    logic [31:0]     flush_pc;
    logic            exc_valid;
    logic [4:0]      exc_cause;
    logic [31:0]     exc_pc;
    logic [63:0]     p_ret, p_cyc, p_exc, p_mis;
  } out_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  rob_head_if #(.COMMIT_W(4), .XLEN(32), .PHYS_W(6), .ROB_IDX_W(5)) rob ();

  logic            lsu_st_ready_i, lsu_st_commit_en_o;
  logic [4:0]      lsu_st_rob_idx_o;
  logic [3:0]      freelist_free_en_o, rat_commit_en_o;
  logic [3:0][5:0] freelist_free_phys_o, rat_commit_phys_o;
  logic [3:0][4:0] rat_commit_arch_o;
  logic            bp_upd_en_o, bp_upd_taken_o, flush_o, exc_valid_o;
  logic [31:0]     bp_upd_pc_o, bp_upd_target_o, flush_pc_o, exc_pc_o;
  logic [4:0]      exc_cause_o;
  logic            mtvec_wen_i;
  logic [31:0]     mtvec_wdata_i;
  logic [63:0]     perf_retired_o, perf_cycles_o, perf_exc_o, perf_mispred_o;
  logic            state_dbg_o;

  retire_unit #(.COMMIT_W(4), .XLEN(32), .PHYS_W(6), .ROB_IDX_W(5), .ARCH_REGS(32)) dut (
    .clk(clk), .reset(reset), .rob(rob),
    .lsu_st_ready_i(lsu_st_ready_i), .lsu_st_commit_en_o(lsu_st_commit_en_o),
    .lsu_st_rob_idx_o(lsu_st_rob_idx_o),
    .freelist_free_en_o(freelist_free_en_o), .freelist_free_phys_o(freelist_free_phys_o),
    .rat_commit_en_o(rat_commit_en_o), .rat_commit_arch_o(rat_commit_arch_o),
    .rat_commit_phys_o(rat_commit_phys_o),
    .bp_upd_en_o(bp_upd_en_o), .bp_upd_pc_o(bp_upd_pc_o), .bp_upd_taken_o(bp_upd_taken_o),
    .bp_upd_target_o(bp_upd_target_o),
    .flush_o(flush_o), .flush_pc_o(flush_pc_o), .exc_valid_o(exc_valid_o),
    .exc_cause_o(exc_cause_o), .exc_pc_o(exc_pc_o),
    .mtvec_wen_i(mtvec_wen_i), .mtvec_wdata_i(mtvec_wdata_i),
    .perf_retired_o(perf_retired_o), .perf_cycles_o(perf_cycles_o),
    .perf_exc_o(perf_exc_o), .perf_mispred_o(perf_mispred_o),
    .state_dbg_o(state_dbg_o)
  );

  // ---------------- bookkeeping ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus state and driver tasks ----------------
  slot_t       cur [CW];
  logic        lsu_ready;
  logic        mt_wen;
  logic [31:0] mt_wdata;

  task automatic clear_slots();
    for (int i = 0; i < CW; i++) cur[i] = '0;
    lsu_ready = 1'b1;
    mt_wen    = 1'b0;
    mt_wdata  = '0;
  endtask

  task automatic alu(input int i, input logic [4:0] arch, input logic [5:0] phys);
    cur[i]       = '0;
    cur[i].valid = 1'b1;
    cur[i].idx   = 5'(i + 8);
    cur[i].arch  = arch;
    cur[i].phys  = phys;
    cur[i].pc    = 32'h1000 + 32'(4 * i);
  endtask

  task automatic store(input int i, input logic [4:0] idx);
    cur[i]       = '0;
    cur[i].valid = 1'b1;
    cur[i].st    = 1'b1;
    cur[i].idx   = idx;
  endtask

  task automatic branch(input int i, input logic taken, input logic mis,
                        input logic [31:0] target, input logic [31:0] pc);
    cur[i]        = '0;
    cur[i].valid  = 1'b1;
    cur[i].br     = 1'b1;
    cur[i].taken  = taken;
    cur[i].mis    = mis;
    cur[i].target = target;
    cur[i].pc     = pc;
  endtask

  task automatic excp(input int i, input logic [4:0] cause, input logic [31:0] pc);
    cur[i]       = '0;
    cur[i].valid = 1'b1;
    cur[i].exc   = 1'b1;
    cur[i].cause = cause;
    cur[i].pc    = pc;
  endtask

  task automatic drive();
    for (int i = 0; i < CW; i++) begin
      rob.rob_valid[i]      = cur[i].valid;
      rob.rob_idx[i]        = cur[i].idx;
      rob.rob_arch_rd[i]    = cur[i].arch;
      rob.rob_phys_rd[i]    = cur[i].phys;
      rob.rob_exc[i]        = cur[i].exc;
      rob.rob_exc_cause[i]  = cur[i].cause;
      rob.rob_is_store[i]   = cur[i].st;
      rob.rob_is_branch[i]  = cur[i].br;
      rob.rob_br_taken[i]   = cur[i].taken;
      rob.rob_br_mispred[i] = cur[i].mis;
      rob.rob_br_target[i]  = cur[i].target;
      rob.rob_pc[i]         = cur[i].pc;
    end
    lsu_st_ready_i = lsu_ready;
    mtvec_wen_i    = mt_wen;
    mtvec_wdata_i  = mt_wdata;
  endtask

  // From posedge+1: drive at +2, return at +3 (cnt is then checkable).
  task automatic go();
    #1;
    drive();
    #1;
  endtask

  // Return at posedge+1 (registered outputs of the last vector are valid).
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  logic [5:0]  m_rat [32];
  logic [31:0] m_mtvec;
  bit          m_recover;
  logic [63:0] m_ret, m_cyc, m_exc, m_mis;
  out_t        exp_q [$];

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_rat[r] = 6'(r);
    m_mtvec   = 32'h100;
    m_recover = 1'b0;
    m_ret = '0; m_cyc = '0; m_exc = '0; m_mis = '0;
  endtask

  // How many head slots go this cycle, from the commit rules.
  function automatic void model_prefix(output int n, output bit exc0, output bit mis);
    int st_seen = 0;
    int br_seen = 0;
    n = 0; exc0 = 1'b0; mis = 1'b0;
    if (cur[0].valid && cur[0].exc) begin
      n = 1; exc0 = 1'b1;
      return;
    end
    for (int i = 0; i < CW; i++) begin
      if (!cur[i].valid || cur[i].exc) break;
      if (cur[i].st && (st_seen > 0 || !lsu_ready)) break;
      if (cur[i].br && br_seen > 0) break;
      st_seen += int'(cur[i].st);
      br_seen += int'(cur[i].br);
      n++;
      if (cur[i].br && cur[i].mis) begin
        mis = 1'b1;
        break;
      end
    end
  endfunction

  function automatic out_t sample_dut();
    out_t a;
    a.st_en = lsu_st_commit_en_o;     a.st_idx = lsu_st_rob_idx_o;
    a.free_en = freelist_free_en_o;   a.free_phys = freelist_free_phys_o;
    a.rat_en = rat_commit_en_o;       a.rat_arch = rat_commit_arch_o;
    a.rat_phys = rat_commit_phys_o;
    a.bp_en = bp_upd_en_o;            a.bp_pc = bp_upd_pc_o;
    a.bp_taken = bp_upd_taken_o;      a.bp_target = bp_upd_target_o;
    a.flush = flush_o;                a.flush_pc = flush_pc_o;
    a.exc_valid = exc_valid_o;        a.exc_cause = exc_cause_o;
    a.exc_pc = exc_pc_o;
    a.p_ret = perf_retired_o;         a.p_cyc = perf_cycles_o;
    a.p_exc = perf_exc_o;             a.p_mis = perf_mispred_o;
    return a;
  endfunction

  // ---------------- per-cycle compare process ----------------
  out_t act, e, nxt;
  int   mn;
  bit   mexc0, mmis;

  always @(negedge clk) begin
    act = sample_dut();
    e   = exp_q.pop_front();
    if (reset) e = '0;
    check("st_en", act.st_en, e.st_en);
    check("st_idx", act.st_idx, e.st_idx);
    check("free_en", act.free_en, e.free_en);
    check("free_phys", act.free_phys, e.free_phys);
    check("rat_en", act.rat_en, e.rat_en);
    check("rat_arch", act.rat_arch, e.rat_arch);
    check("rat_phys", act.rat_phys, e.rat_phys);
    check("bp_en", act.bp_en, e.bp_en);
    check("bp_pc", act.bp_pc, e.bp_pc);
    check("bp_taken", act.bp_taken, e.bp_taken);
    check("bp_target", act.bp_target, e.bp_target);
    check("flush", act.flush, e.flush);
    check("flush_pc", act.flush_pc, e.flush_pc);
    check("exc_valid", act.exc_valid, e.exc_valid);
    check("exc_cause", act.exc_cause, e.exc_cause);
    check("exc_pc", act.exc_pc, e.exc_pc);
    check("perf_retired", act.p_ret, e.p_ret);
    check("perf_cycles", act.p_cyc, e.p_cyc);
    check("perf_exc", act.p_exc, e.p_exc);
    check("perf_mispred", act.p_mis, e.p_mis);
    check("state_recover", state_dbg_o, (!reset && m_recover) ? 64'd1 : 64'd0);

    if (reset || m_recover) begin
      mn = 0; mexc0 = 1'b0; mmis = 1'b0;
    end else begin
      model_prefix(mn, mexc0, mmis);
    end
    check("retire_cnt", rob.rob_retire_cnt, 64'(mn));

    if (reset) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      nxt = '0;
      if (mexc0) begin
        nxt.flush     = 1'b1;
        nxt.flush_pc  = m_mtvec;
        nxt.exc_valid = 1'b1;
        nxt.exc_cause = cur[0].cause;
        nxt.exc_pc    = cur[0].pc;
      end else begin
        for (int i = 0; i < mn; i++) begin
          nxt.rat_en[i]   = 1'b1;
          nxt.rat_arch[i] = cur[i].arch;
          nxt.rat_phys[i] = cur[i].phys;
          if (cur[i].arch != 0) begin
            nxt.free_en[i]     = 1'b1;
            nxt.free_phys[i]   = m_rat[cur[i].arch];
            m_rat[cur[i].arch] = cur[i].phys;
          end
          if (cur[i].st) begin
            nxt.st_en  = 1'b1;
            nxt.st_idx = cur[i].idx;
          end
          if (cur[i].br) begin
            nxt.bp_en     = 1'b1;
            nxt.bp_pc     = cur[i].pc;
            nxt.bp_taken  = cur[i].taken;
            nxt.bp_target = cur[i].target;
            if (cur[i].mis) begin
              nxt.flush    = 1'b1;
              nxt.flush_pc = cur[i].taken ? cur[i].target : cur[i].pc + 32'd4;
            end
          end
        end
      end
      m_cyc += 64'd1;
      m_ret += 64'(mn - int'(mexc0));
      m_exc += 64'(mexc0);
      m_mis += 64'(mmis);
`ifdef RETIRE_PERF_COUNTERS_EN
      nxt.p_ret = m_ret;
      nxt.p_cyc = m_cyc;
      nxt.p_exc = m_exc;
      nxt.p_mis = m_mis;
`endif
      m_recover = mexc0 || mmis;
      if (mt_wen) m_mtvec = mt_wdata;
      exp_q.push_back(nxt);
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    model_reset();
    exp_q.push_back('0);
    clear_slots();
    drive();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("reset_rat_en", rat_commit_en_o, 64'd0);
    edge1();

    // idle after reset
    clear_slots(); go();
    check("idle_cnt", rob.rob_retire_cnt, 64'd0);
    edge1();
    check("idle_flush", flush_o, 64'd0);

    // four ALU ops, arch 1..4 -> phys 40..43
    clear_slots();
    for (int i = 0; i < 4; i++) alu(i, 5'(i + 1), 6'(40 + i));
    go();
    check("alu4_cnt", rob.rob_retire_cnt, 64'd4);
    edge1();
    check("alu4_free_en", freelist_free_en_o, 64'hF);
    check("alu4_free_phys", freelist_free_phys_o, {6'd4, 6'd3, 6'd2, 6'd1});
    check("alu4_rat_en", rat_commit_en_o, 64'hF);
    // same arch regs again: frees 40..43, proving RAT[1..4]=40..43
    for (int i = 0; i < 4; i++) alu(i, 5'(i + 1), 6'(44 + i));
    go();
    edge1();
    check("alu4b_free_phys", freelist_free_phys_o, {6'd43, 6'd42, 6'd41, 6'd40});

    // duplicate arch_rd 7 in one group
    clear_slots(); alu(0, 5'd7, 6'd50); alu(1, 5'd7, 6'd51);
    go();
    check("dup_cnt", rob.rob_retire_cnt, 64'd2);
    edge1();
    check("dup_free_en", freelist_free_en_o, 64'h3);
    check("dup_free_phys", freelist_free_phys_o[1:0], {6'd50, 6'd7});
    clear_slots(); alu(0, 5'd7, 6'd52);
    go();
    edge1();
    check("dup_rat7", freelist_free_phys_o[0], 64'd51);

    // two stores
    clear_slots(); store(0, 5'd3); store(1, 5'd4);
    go();
    check("st2_cnt", rob.rob_retire_cnt, 64'd1);
    edge1();
    check("st2_en", lsu_st_commit_en_o, 64'd1);
    check("st2_idx", lsu_st_rob_idx_o, 64'd3);
    lsu_ready = 1'b0;
    go();
    check("st_notready_cnt", rob.rob_retire_cnt, 64'd0);
    edge1();
    check("st_notready_en", lsu_st_commit_en_o, 64'd0);

    // two correctly predicted branches: only the first goes
    clear_slots();
    branch(0, 1'b1, 1'b0, 32'h3000, 32'h500);
    branch(1, 1'b0, 1'b0, 32'h3100, 32'h504);
    go();
    check("br2_cnt", rob.rob_retire_cnt, 64'd1);
    edge1();
    check("br2_bp_pc", bp_upd_pc_o, 64'h500);
    check("br2_flush", flush_o, 64'd0);

    // exception on slot 2 only ends the prefix
    clear_slots(); alu(0, 5'd5, 6'd20); alu(1, 5'd6, 6'd21); excp(2, 5'd9, 32'h88);
    go();
    check("exc2_cnt", rob.rob_retire_cnt, 64'd2);
    edge1();
    check("exc2_valid", exc_valid_o, 64'd0);

    // taken mispredict at slot 1
    clear_slots();
    alu(0, 5'd8, 6'd30);
    branch(1, 1'b1, 1'b1, 32'h2000, 32'h600);
    alu(2, 5'd9, 6'd31); alu(3, 5'd10, 6'd32);
    go();
    check("mis_cnt", rob.rob_retire_cnt, 64'd2);
    edge1();
    check("mis_flush", flush_o, 64'd1);
    check("mis_flush_pc", flush_pc_o, 64'h2000);
    check("mis_bp_taken", bp_upd_taken_o, 64'd1);
    clear_slots();
    for (int i = 0; i < 4; i++) alu(i, 5'(11 + i), 6'(33 + i));
    go();
    check("recover_cnt", rob.rob_retire_cnt, 64'd0);
    edge1();
    check("recover_flush", flush_o, 64'd0);
    go();
    check("after_recover_cnt", rob.rob_retire_cnt, 64'd4);
    edge1();

    // not-taken mispredict at the top of the address space wraps to 0
    clear_slots();
    branch(0, 1'b0, 1'b1, 32'h1234, 32'hFFFF_FFFC); alu(1, 5'd3, 6'd9);
    go();
    check("nt_cnt", rob.rob_retire_cnt, 64'd1);
    edge1();
    check("nt_flush_pc", flush_pc_o, 64'd0);
    clear_slots(); go(); edge1();

    // exception on slot 0 after mtvec=0x400
    clear_slots(); mt_wen = 1'b1; mt_wdata = 32'h400;
    go(); edge1();
    clear_slots(); excp(0, 5'd5, 32'h80); alu(1, 5'd2, 6'd12);
    go();
    check("exc0_cnt", rob.rob_retire_cnt, 64'd1);
    edge1();
    check("exc0_valid", exc_valid_o, 64'd1);
    check("exc0_cause", exc_cause_o, 64'd5);
    check("exc0_pc", exc_pc_o, 64'h80);
    check("exc0_flush_pc", flush_pc_o, 64'h400);
    check("exc0_free_en", freelist_free_en_o, 64'd0);
    clear_slots(); go(); edge1();

    // mtvec write in the same cycle as an exception: old vector used
    clear_slots(); excp(0, 5'd3, 32'h90); mt_wen = 1'b1; mt_wdata = 32'h800;
    go(); edge1();
    check("exc_oldvec", flush_pc_o, 64'h400);
    clear_slots(); go(); edge1();
    clear_slots(); excp(0, 5'd4, 32'hA0);
    go(); edge1();
    check("exc_newvec", flush_pc_o, 64'h800);
    clear_slots(); go(); edge1();

    // reset in the middle of RECOVER
    clear_slots(); alu(0, 5'd1, 6'd60); branch(1, 1'b1, 1'b1, 32'h4000, 32'h700);
    go(); edge1();
    check("rst_pre_flush", flush_o, 64'd1);
    #1 reset = 1'b1;
    clear_slots();
    for (int i = 0; i < 4; i++) alu(i, 5'(i + 1), 6'(37 + i));
    drive();
    #1;
    check("rst_cnt", rob.rob_retire_cnt, 64'd0);
    check("rst_flush", flush_o, 64'd0);
    check("rst_flush_pc", flush_pc_o, 64'd0);
    check("rst_bp_en", bp_upd_en_o, 64'd0);
    check("rst_state", state_dbg_o, 64'd0);
    edge1();
    #1 reset = 1'b0;
    drive();
    #1;
    check("post_rst_cnt", rob.rob_retire_cnt, 64'd4);
    edge1();
    check("post_rst_free_phys", freelist_free_phys_o, {6'd4, 6'd3, 6'd2, 6'd1});

    clear_slots(); go(); edge1(); edge1();
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/retire_unit.md
RETIRE_UNIT -- requirements
Module: retire_unit

Interface
REQ-001 SHALL have parameter COMMIT_W, 4, retire slots per cycle (1..8).
REQ-002 SHALL have parameter XLEN, 32, data/PC width.
REQ-003 SHALL have parameter PHYS_W, 6, physical tag width.
REQ-004 SHALL have parameter ROB_IDX_W, 5, ROB index width.
REQ-005 SHALL have parameter ARCH_REGS, 32, architectural registers.
REQ-006 SHALL have ports: clk in 1 clock; reset in 1, asynchronous, active-high.
REQ-007 SHALL have ROB head inputs, COMMIT_W-wide or per-slot arrays, slot 0 oldest:
- rob_valid
- rob_idx[ROB_IDX_W]
- rob_arch_rd[5]
- rob_phys_rd[PHYS_W]
- rob_exc
- rob_exc_cause[5]
- rob_is_store
- rob_is_branch
- rob_br_taken
- rob_br_mispred
- rob_br_target[XLEN]
- rob_pc[XLEN]
REQ-008 SHALL have rob_retire_cnt out $clog2(COMMIT_W+1), the number of head entries popped this cycle.
REQ-009 SHALL have lsu_st_ready in 1; lsu_st_commit_en out 1; lsu_st_rob_idx out ROB_IDX_W.
REQ-010 SHALL have freelist_free_en out COMMIT_W; freelist_free_phys out per-slot PHYS_W.
REQ-011 SHALL have rat_commit_en out COMMIT_W; rat_commit_arch out per-slot 5; rat_commit_phys out per-slot PHYS_W.
REQ-012 SHALL have branch-predictor outputs: bp_upd_en out 1; bp_upd_pc out XLEN; bp_upd_taken out 1; bp_upd_target out XLEN.
REQ-013 SHALL have flush out 1; flush_pc out XLEN; exc_valid out 1; exc_cause out 5; exc_pc out XLEN.
REQ-014 SHALL have mtvec_wen in 1; mtvec_wdata in XLEN.
REQ-015 SHALL have perf_retired, perf_cycles, perf_exc, perf_mispred, each out 64.

Function
REQ-016 SHALL compute rob_retire_cnt combinationally as the longest contiguous retirable prefix from slot 0. Slot i is retirable only if all of the following hold:
- state is RUN;
- rob_valid[i] is set;
- rob_exc[i] is clear;
- it is not a second store, and, if it is a store, lsu_st_ready is high;
- it is not a second branch.
REQ-017 SHALL retire a mispredicted branch and then end the prefix; younger slots are not retired.
REQ-018 SHALL handle an exception as follows:
- rob_exc on slot 0 in RUN pops that entry (cnt=1) with no RAT or free-list update;
- it raises exc_valid/flush and enters state RECOVER;
- rob_exc on slot i>0 only ends the prefix at i.
REQ-019 SHALL implement FSM states RUN and RECOVER. Transitions: RUN->RECOVER on an exception or mispredict retirement; RECOVER->RUN after exactly 1 cycle. In RECOVER, rob_retire_cnt=0.
REQ-020 SHALL register all outputs except rob_retire_cnt one cycle after the retire cycle; each output pulse lasts 1 cycle.
REQ-021 SHALL, for each retired slot with arch_rd!=0, assert freelist_free_en with the previous committed mapping and update the internal committed RAT to rob_phys_rd.
REQ-022 SHALL resolve same-cycle duplicate arch_rd in slot order: the younger slot frees the older slot's phys_rd, and the final RAT entry equals the youngest slot's phys_rd.
REQ-023 SHALL assert rat_commit_en[i] for every retired slot, including arch_rd=0.
REQ-024 SHALL, for a retired store, assert lsu_st_commit_en with lsu_st_rob_idx=rob_idx of that slot.
REQ-025 SHALL, for a retired branch, assert bp_upd_en with pc, taken, and target.
REQ-026 SHALL, on a mispredict, set flush_pc to rob_br_target if taken, otherwise rob_pc+4 (mod 2^XLEN).
REQ-027 SHALL, on an exception, set exc_cause=rob_exc_cause[0], exc_pc=rob_pc[0], and flush_pc=mtvec.
REQ-028 SHALL update the mtvec register on the clock after mtvec_wen. An exception in that same cycle uses the old mtvec.
REQ-029 SHALL update performance counters as follows, each wrapping modulo 2^64:
- perf_cycles +1 every cycle;
- perf_retired += count of retired non-exception entries;
- perf_exc +1 per exception;
- perf_mispred +1 per mispredict.

Reset
REQ-030 SHALL, on reset, immediately set the following, including in the middle of a RECOVER cycle:
- state=RUN;
- committed RAT[i]=i;
- mtvec=0x0000_0100;
- all enables, flush, exc_valid and counters = 0;
- all data outputs = 0.
REQ-031 SHALL hold rob_retire_cnt=0 while reset is asserted.

Configuration
REQ-032 SHALL support macro RETIRE_PERF_COUNTERS_EN. When defined, the REQ-029 counters are implemented. When undefined, all perf_* outputs are constant 0 and no counter flops exist.

Verification
REQ-033 SHALL cover this scenario: COMMIT_W=4, 4 valid ALU ops with arch_rd 1,2,3,4 and phys 40..43 -> cnt=4; next cycle free_phys 1,2,3,4, RAT[1..4]=40..43.
REQ-034 SHALL cover this scenario: slots 0,1 both stores, lsu_st_ready=1 -> cnt=1, lsu_st_rob_idx=rob_idx[0]. Same with lsu_st_ready=0 -> cnt=0.
REQ-035 SHALL cover this scenario: slot1 is a taken mispredicted branch with target 0x2000, slots 2-3 valid -> cnt=2; next cycle flush=1, flush_pc=0x2000, bp_upd_taken=1; following cycle cnt=0.
REQ-036 SHALL cover this scenario: slot 0 has exception with cause 5 and pc 0x80, after mtvec write 0x400 -> cnt=1, exc_valid=1, exc_cause=5, exc_pc=0x80, flush_pc=0x400, no free_en.
REQ-037 SHALL cover this scenario: slots 0,1 both write arch_rd 7 with phys 50,51, old RAT[7]=7 -> free_phys 7 and 50, RAT[7]=51.
REQ-038 SHALL cover this scenario: reset asserted mid-RECOVER -> all outputs 0, RAT identity, next valid group retires normally.
